handshake_constant_seq: RTL and testbench
=========================================

// Module: handshake_constant_seq
// PURPOSE
//  Parametrised successor of the single-value handshake constant. Each accepted
//  ctrl token emits the next value from a compile-time table of NUM_VALUES constants.
//  The index wraps or saturates, and a synchronous restart returns it to entry 0.
//  Output is registered through a 2-entry skid buffer: no comb path valid->valid or
//  ready->ready. Sits in dataflow circuits wherever a constant stream is triggered by control.
// PARAMETERS
//  DATA_WIDTH  32       width of each constant and of outs
//  NUM_VALUES  4        table entries, >=1
//  VALUES      {32'h3,32'h2,32'h1,32'h15}  flat table; entry i = VALUES[i*DATA_WIDTH +: DATA_WIDTH]
//  WRAP        1        1: index wraps to 0 after last entry; 0: index saturates at NUM_VALUES-1
//  IDX_W       (NUM_VALUES>1 ? $clog2(NUM_VALUES) : 1)   derived index width, not overridden
// PORTS
//  clk         in   1           clock, all state on rising edge
//  rst         in   1           asynchronous, active-low reset (0 = reset)
//  restart     in   1           sync; resets index to 0 (see behaviour)
//  ctrl_valid  in   1           control token present
//  ctrl_ready  out  1           block accepts token this cycle
//  outs        out  DATA_WIDTH  constant value of head token
//  outs_valid  out  1           head token valid
//  outs_ready  in   1           consumer accepts head token
//  idx         out  IDX_W       table index the next accepted token will use (restart=0)
// BEHAVIOUR
//  Reset (rst=0, async): main/skid invalid, main/skid data=0, idx=0 -> outs=0,
//   outs_valid=0, ctrl_ready=0 while rst=0; ctrl_ready=1 from first cycle after release.
//  in_fire = ctrl_valid & ctrl_ready; out_fire = outs_valid & outs_ready.
//  ctrl_ready = rst & ~skid_valid (register-only, no dependence on outs_ready).
//  Selection: sel = restart ? 0 : idx; the accepted token carries VALUES[sel].
//  Index update on in_fire: sel==NUM_VALUES-1 -> (WRAP ? 0 : NUM_VALUES-1), else sel+1.
//   No in_fire: idx <= restart ? 0 : idx. NUM_VALUES==1: idx always 0.
//  restart never affects tokens already buffered.
//  Buffer FSM (outs = main data, outs_valid = main valid):
//   EMPTY: in_fire -> main<=val, ONE.
//   ONE:   in&out -> main<=val, stay ONE; in&~out -> skid<=val, FULL;
//          ~in&out -> EMPTY; neither -> hold.
//   FULL:  ctrl_ready=0; out_fire -> main<=skid, skid invalid, ONE; else hold.
//  Latency: token accepted at edge N is on outs with outs_valid=1 after edge N (1 cycle).
//  Throughput: 1 token/cycle sustained while outs_ready=1.
//  Ordering: tokens leave strictly in acceptance order; no drop, no duplication.
//  outs/outs_valid stable while outs_valid=1 & outs_ready=0 (AXI-style hold).
//  Reset mid-operation: all buffered tokens discarded, idx=0, restart behaviour as reset.
// TESTING
//  T1 reset: rst=0 with ctrl_valid=1 -> outs_valid=0, ctrl_ready=0, outs=0, idx=0;
//     release -> ctrl_ready=1 next cycle.
//  T2 stream: ctrl_valid=1, outs_ready=1 for 6 cycles, defaults -> outs 0x15,1,2,3,0x15,1
//     on consecutive cycles, 1 cycle after each accept.
//  T3 backpressure: outs_ready=0, ctrl_valid=1 -> accepts 2 tokens (0x15,1), ctrl_ready=0
//     on 3rd cycle; outs held 0x15; release -> 0x15,1,2 in order, no gaps.
//  T4 saturate: WRAP=0, 6 tokens -> outs 0x15,1,2,3,3,3; idx stays 3.
//  T5 restart: after 2 tokens assert restart with in_fire -> that token = 0x15, idx=1;
//     restart without in_fire -> idx=0, buffered tokens unchanged.
//  T6 random valid/ready 10k cycles vs scoreboard model; rst pulse mid-run flushes buffer.

Source files
------------

// File: rtl/handshake_constant_seq.sv
// Purpose  : each accepted ctrl token emits the next entry of a compile-time constant table.
// Latency  : 1 cycle from ctrl accept to outs_valid; sustains 1 token/cycle.
// Backpress: 2-entry skid buffer; ctrl_ready is a pure register decode, never follows outs_ready.
//
// Ports
//   clk         rising-edge clock for all state
//   rst         asynchronous active-low reset (0 = reset)
//   restart     synchronous: the token accepted this cycle uses entry 0, index returns to 0
//   ctrl_valid  control token present            ctrl_ready  token accepted this cycle
//   outs        constant carried by head token   outs_valid  head token present
//   outs_ready  consumer takes head token        idx         entry the next accepted token uses
module handshake_constant_seq #(
   parameter int                              DATA_WIDTH = 32,
   parameter int                              NUM_VALUES = 4,
   parameter logic [NUM_VALUES*DATA_WIDTH-1:0] VALUES     = {32'h3, 32'h2, 32'h1, 32'h15},
   parameter bit                              WRAP       = 1'b1,
   localparam int                             IDX_W      = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  restart,
   input  logic                  ctrl_valid,
   output logic                  ctrl_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic                  outs_valid,
   input  logic                  outs_ready,
   output logic [IDX_W-1:0]      idx
);

   // Elaboration-time sanity on the table shape.
   if (NUM_VALUES < 1) begin : g_bad_num_values
      $error("handshake_constant_seq: NUM_VALUES must be >= 1");
   end
   if (DATA_WIDTH < 1) begin : g_bad_data_width
      $error("handshake_constant_seq: DATA_WIDTH must be >= 1");
   end

   // Buffer occupancy. The state encodes both valid bits:
   //   EMPTY: nothing held; ONE: main holds the head token; FULL: main + skid both hold tokens.
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VALUES - 1);

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] main_dat_q, main_dat_d;
   logic [DATA_WIDTH-1:0] skid_dat_q, skid_dat_d;
   logic [IDX_W-1:0]      idx_q, idx_d;

   logic                  main_vld;
   logic                  skid_vld;
   logic                  accept;
   logic                  in_fire;
   logic                  out_fire;
   logic [IDX_W-1:0]      sel;
   logic [DATA_WIDTH-1:0] sel_val;

   assign main_vld = (state_q == ONE) || (state_q == FULL);
   assign skid_vld = (state_q == FULL);

   // Externally the block is never ready while held in reset. Internally the
   // state update can ignore rst: every register is forced clear while rst=0,
   // so gating the next-state logic with rst would change nothing.
   assign accept     = ~skid_vld;
   assign ctrl_ready = rst & accept;
   assign in_fire    = ctrl_valid & accept;
   assign out_fire   = main_vld & outs_ready;

   assign outs       = main_dat_q;
   assign outs_valid = main_vld;
   assign idx        = idx_q;

   // restart redirects the token accepted in the same cycle to entry 0.
   assign sel = restart ? '0 : idx_q;

   // Table lookup; written as a compare-and-select so non-power-of-two tables
   // never index past the flat parameter.
   always_comb begin
      sel_val = '0;
      for (int i = 0; i < NUM_VALUES; i++) begin
         if (sel == IDX_W'(i)) begin
            sel_val = VALUES[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Index advance. With a single-entry table sel is always 0 == LAST_IDX,
   // so both WRAP settings keep the index at 0.
   always_comb begin
      idx_d = sel;
      if (in_fire) begin
         if (sel == LAST_IDX) begin
            idx_d = WRAP ? '0 : LAST_IDX;
         end else begin
            idx_d = sel + IDX_W'(1);
         end
      end
   end

   // Skid buffer next state. New tokens always enter main when main is free or
   // being drained in the same cycle; skid is only filled when main stalls.
   always_comb begin
      state_d    = state_q;
      main_dat_d = main_dat_q;
      skid_dat_d = skid_dat_q;
      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               main_dat_d = sel_val;
               state_d    = ONE;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_dat_d = sel_val;
            end else if (in_fire) begin
               skid_dat_d = sel_val;
               state_d    = FULL;
            end else if (out_fire) begin
               state_d    = EMPTY;
            end
         end
         FULL: begin
            // ctrl_ready is low here, so only the drain side can move.
            if (out_fire) begin
               main_dat_d = skid_dat_q;
               state_d    = ONE;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= EMPTY;
         main_dat_q <= '0;
         skid_dat_q <= '0;
         idx_q      <= '0;
      end else begin
         state_q    <= state_d;
         main_dat_q <= main_dat_d;
         skid_dat_q <= skid_dat_d;
         idx_q      <= idx_d;
      end
   end

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Purpose  : directed and randomised checks of handshake_constant_seq (wrap and saturate builds).
// Latency  : n/a (testbench).
// Backpress: drives outs_ready directly, including long stalls.
module tb_handshake_constant_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   // Instance A: default table, WRAP=1
   logic        restart    = 1'b0;
   logic        ctrl_valid = 1'b0;
   logic        outs_ready = 1'b0;
   logic        ctrl_ready;
   logic [31:0] outs;
   logic        outs_valid;
   logic [1:0]  idx;

   // Instance B: default table, WRAP=0
   logic        restart_b    = 1'b0;
   logic        ctrl_valid_b = 1'b0;
   logic        outs_ready_b = 1'b0;
   logic        ctrl_ready_b;
   logic [31:0] outs_b;
   logic        outs_valid_b;
   logic [1:0]  idx_b;

   int checks   = 0;
   int failures = 0;

   handshake_constant_seq u_dut (
      .clk        (clk),
      .rst        (rst),
      .restart    (restart),
      .ctrl_valid (ctrl_valid),
      .ctrl_ready (ctrl_ready),
      .outs       (outs),
      .outs_valid (outs_valid),
      .outs_ready (outs_ready),
      .idx        (idx)
   );

   handshake_constant_seq #(.WRAP(1'b0)) u_dut_sat (
      .clk        (clk),
      .rst        (rst),
      .restart    (restart_b),
      .ctrl_valid (ctrl_valid_b),
      .ctrl_ready (ctrl_ready_b),
      .outs       (outs_b),
      .outs_valid (outs_valid_b),
      .outs_ready (outs_ready_b),
      .idx        (idx_b)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One rising edge, then settle just past the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b0;
      restart      = 1'b0;
      ctrl_valid   = 1'b0;
      outs_ready   = 1'b0;
      restart_b    = 1'b0;
      ctrl_valid_b = 1'b0;
      outs_ready_b = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   // Hand-computed expectations; table order is 0x15, 1, 2, 3.
   logic [31:0] t2_outs [6] = '{32'h15, 32'h1, 32'h2, 32'h3, 32'h15, 32'h1};
   logic [31:0] t2_idx  [6] = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2};
   logic [31:0] t4_outs [6] = '{32'h15, 32'h1, 32'h2, 32'h3, 32'h3, 32'h3};
   logic [31:0] t4_idx  [6] = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3, 32'd3};
   logic [31:0] tbl     [4] = '{32'h15, 32'h1, 32'h2, 32'h3};

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] q[$];
      int          midx;
      int          sel;
      logic        exp_rdy;

      // T1: reset holds everything quiet even with a token offered.
      rst          = 1'b0;
      ctrl_valid   = 1'b1;
      ctrl_valid_b = 1'b1;
      outs_ready   = 1'b0;
      step();
      step();
      check_eq("t1_outs_valid", outs_valid, 0);
      check_eq("t1_ctrl_ready", ctrl_ready, 0);
      check_eq("t1_outs", outs, 0);
      check_eq("t1_idx", idx, 0);
      check_eq("t1_b_ctrl_ready", ctrl_ready_b, 0);
      ctrl_valid   = 1'b0;
      ctrl_valid_b = 1'b0;
      rst          = 1'b1;
      step();
      check_eq("t1_ready_after_release", ctrl_ready, 1);
      check_eq("t1_valid_after_release", outs_valid, 0);

      // T2: full-rate stream with wrap.
      ctrl_valid = 1'b1;
      outs_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         check_eq("t2_valid", outs_valid, 1);
         check_eq("t2_outs", outs, t2_outs[k]);
         check_eq("t2_idx", idx, t2_idx[k]);
         check_eq("t2_ready", ctrl_ready, 1);
      end
      ctrl_valid = 1'b0;
      step();
      check_eq("t2_drained", outs_valid, 0);

      // T3: backpressure fills main then skid, then drains in order.
      do_reset();
      ctrl_valid = 1'b1;
      outs_ready = 1'b0;
      step();
      check_eq("t3_outs_1", outs, 32'h15);
      check_eq("t3_valid_1", outs_valid, 1);
      check_eq("t3_ready_1", ctrl_ready, 1);
      step();
      check_eq("t3_outs_2", outs, 32'h15);
      check_eq("t3_ready_full", ctrl_ready, 0);
      step();
      check_eq("t3_outs_hold", outs, 32'h15);
      check_eq("t3_ready_hold", ctrl_ready, 0);
      check_eq("t3_idx_hold", idx, 2);
      outs_ready = 1'b1;
      step();
      check_eq("t3_outs_skid", outs, 32'h1);
      check_eq("t3_valid_skid", outs_valid, 1);
      check_eq("t3_ready_again", ctrl_ready, 1);
      step();
      check_eq("t3_outs_next", outs, 32'h2);
      check_eq("t3_valid_next", outs_valid, 1);
      ctrl_valid = 1'b0;
      step();
      check_eq("t3_drained", outs_valid, 0);

      // T4: saturating build sticks at the last entry.
      do_reset();
      ctrl_valid_b = 1'b1;
      outs_ready_b = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         check_eq("t4_valid", outs_valid_b, 1);
         check_eq("t4_outs", outs_b, t4_outs[k]);
         check_eq("t4_idx", idx_b, t4_idx[k]);
      end
      ctrl_valid_b = 1'b0;
      step();
      check_eq("t4_drained", outs_valid_b, 0);

      // T5: restart with and without an accepted token.
      do_reset();
      ctrl_valid = 1'b1;
      outs_ready = 1'b1;
      step();
      check_eq("t5_outs_a", outs, 32'h15);
      step();
      check_eq("t5_outs_b", outs, 32'h1);
      check_eq("t5_idx_b", idx, 2);
      restart = 1'b1;
      step();
      check_eq("t5_restart_tok", outs, 32'h15);
      check_eq("t5_restart_idx", idx, 1);
      ctrl_valid = 1'b0;
      outs_ready = 1'b0;
      step();
      check_eq("t5_idle_restart_idx", idx, 0);
      check_eq("t5_buffered_outs", outs, 32'h15);
      check_eq("t5_buffered_valid", outs_valid, 1);
      restart    = 1'b0;
      outs_ready = 1'b1;
      step();
      check_eq("t5_drained", outs_valid, 0);

      // T6: random traffic against a queue model, with a reset pulse mid-run.
      do_reset();
      midx = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         ctrl_valid = ($urandom_range(0, 3) != 0);
         outs_ready = ($urandom_range(0, 1) != 0);
         restart    = ($urandom_range(0, 15) == 0);
         rst        = !(cyc >= 5000 && cyc < 5003);
         if (!rst) begin
            q.delete();
            midx = 0;
         end
         #1;
         exp_rdy = rst && (q.size() < 2);
         check_eq("t6_ready", ctrl_ready, exp_rdy);
         check_eq("t6_valid", outs_valid, (q.size() > 0));
         check_eq("t6_idx", idx, midx);
         if (q.size() > 0) begin
            check_eq("t6_outs", outs, q[0]);
         end else if (!rst) begin
            check_eq("t6_outs_rst", outs, 0);
         end
         if (rst) begin
            sel = restart ? 0 : midx;
            if (q.size() > 0 && outs_ready) begin
               void'(q.pop_front());
            end
            if (ctrl_valid && exp_rdy) begin
               q.push_back(tbl[sel]);
               midx = (sel == 3) ? 0 : sel + 1;
            end else begin
               midx = sel;
            end
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
